// File: rtl/add_sub_serial_if.sv
// Operand/result bundle for the digit-serial adder/subtractor: request side plus result side.
// Latency: none; plain wires grouped so the block and its user share one connection.
// Backpressure: start is honoured only while ready is high; the master holds nothing after acceptance.
interface add_sub_serial_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output start, sub, a, b,
        input  ready, busy, done, sum, cout, ovf
    );

    modport slave (
        input  start, sub, a, b,
        output ready, busy, done, sum, cout, ovf
    );
endinterface

// File: rtl/add_sub_serial.sv
// Digit-serial two's-complement add/subtract, DIGIT bits per cycle LSB first; optional clamp via ADD_SUB_SAT_EN.
// Latency: N = WIDTH/DIGIT cycles from start acceptance to the one-cycle done pulse; sum/cout/ovf held until next result.
// Backpressure: ready low during RUN (start ignored); a start in the DONE cycle restarts, giving one result per N+1 cycles.
module add_sub_serial #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    add_sub_serial_if.slave bus
);
    localparam int N     = WIDTH / DIGIT;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] res_nxt;
    logic [WIDTH-1:0] sum_fin;
    logic [WIDTH-1:0] sum_q;
    logic             carry;
    logic             cout_q;
    logic             ovf_q;
    logic [CNT_W-1:0] cnt;
    logic             load;
    logic             step;
    logic             last;
    logic [DIGIT-1:0] dsum;
    logic [DIGIT:0]   chain;
    logic             ovf_nxt;

    assign last = (cnt == CNT_W'(N - 1));

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode: accept in IDLE or DONE, step every RUN cycle, leave RUN on the last digit.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        step      = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    load      = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (bus.start) begin
                    load      = 1'b1;
                    state_nxt = RUN;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Ripple the registered carry through DIGIT full-adder cells on the low operand bits.
    always_comb begin
        chain    = '0;
        dsum     = '0;
        chain[0] = carry;
        for (int i = 0; i < DIGIT; i++) begin
            dsum[i]      = op_a[i] ^ op_b[i] ^ chain[i];
            chain[i+1]   = (op_a[i] & op_b[i]) | (chain[i] & (op_a[i] ^ op_b[i]));
        end
    end

    // New digit enters at the top so after N steps the result sits LSB-aligned.
    assign res_nxt = (res >> DIGIT) | (WIDTH'(dsum) << (WIDTH - DIGIT));

    // On the last digit chain[DIGIT-1] is the carry into the MSB.
    assign ovf_nxt = chain[DIGIT] ^ chain[DIGIT-1];

`ifdef ADD_SUB_SAT_EN
    // Clamp on overflow; op_a[DIGIT-1] holds A's original MSB during the final digit.
    always_comb begin
        sum_fin = res_nxt;
        if (ovf_nxt) begin
            sum_fin = op_a[DIGIT-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                    : {1'b0, {(WIDTH-1){1'b1}}};
        end
    end
`else
    assign sum_fin = res_nxt;
`endif

    // Operand shift registers, carry, digit counter and the held result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a   <= '0;
            op_b   <= '0;
            res    <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (load) begin
            op_a  <= bus.a;
            op_b  <= bus.b ^ {WIDTH{bus.sub}};
            carry <= bus.sub;
            cnt   <= '0;
            res   <= '0;
        end else if (step) begin
            op_a  <= op_a >> DIGIT;
            op_b  <= op_b >> DIGIT;
            carry <= chain[DIGIT];
            cnt   <= cnt + 1'b1;
            res   <= res_nxt;
            if (last) begin
                sum_q  <= sum_fin;
                cout_q <= chain[DIGIT];
                ovf_q  <= ovf_nxt;
            end
        end
    end

    assign bus.ready = (state == IDLE) || (state == DONE);
    assign bus.busy  = (state == RUN);
    assign bus.done  = (state == DONE);
    assign bus.sum   = sum_q;
    assign bus.cout  = cout_q;
    assign bus.ovf   = ovf_q;
endmodule

// File: tb/tb_add_sub_serial.sv
// Bench for add_sub_serial: three instances (DIGIT=1,2,4, WIDTH=8) against an integer-arithmetic model.
// Latency: checks done arrives exactly N cycles after acceptance and restarts are N+1 apart.
// Backpressure: exercises start held through RUN/DONE, a stray mid-RUN start and reset mid-operation.
module tb_add_sub_serial;
    logic clk;
    logic rst_n;

    logic [2:0]      st_start;
    logic [2:0]      st_sub;
    logic [2:0][7:0] st_a;
    logic [2:0][7:0] st_b;
    logic [2:0]      o_ready;
    logic [2:0]      o_busy;
    logic [2:0]      o_done;
    logic [2:0][7:0] o_sum;
    logic [2:0]      o_cout;
    logic [2:0]      o_ovf;

    int n_checks;
    int n_errors;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        add_sub_serial_if #(.WIDTH(8)) bus ();
        assign bus.start  = st_start[g];
        assign bus.sub    = st_sub[g];
        assign bus.a      = st_a[g];
        assign bus.b      = st_b[g];
        assign o_ready[g] = bus.ready;
        assign o_busy[g]  = bus.busy;
        assign o_done[g]  = bus.done;
        assign o_sum[g]   = bus.sum;
        assign o_cout[g]  = bus.cout;
        assign o_ovf[g]   = bus.ovf;
        add_sub_serial #(.WIDTH(8), .DIGIT(1 << g)) dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (bus)
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: signed/unsigned integer arithmetic on the whole operands.
    function automatic void model(input logic [7:0] a, input logic [7:0] b, input logic s,
                                  output logic [7:0] es, output logic ec, output logic eo);
        int sa;
        int sb;
        int tr;
        sa = int'($signed(a));
        sb = int'($signed(b));
        tr = s ? (sa - sb) : (sa + sb);
        eo = (tr > 127) || (tr < -128);
        ec = s ? (a >= b) : ((int'(a) + int'(b)) > 255);
        es = tr[7:0];
`ifdef ADD_SUB_SAT_EN
        if (eo) es = (tr > 0) ? 8'h7F : 8'h80;
`endif
    endfunction

    task automatic check_result(input string tag, input int k,
                                input logic [7:0] es, input logic ec, input logic eo);
        check({tag, " sum"},  32'(o_sum[k]),  32'(es));
        check({tag, " cout"}, 32'(o_cout[k]), 32'(ec));
        check({tag, " ovf"},  32'(o_ovf[k]),  32'(eo));
    endtask

    // Single operation on instance k with start pulsed for one cycle.
    task automatic do_op(input int k, input logic [7:0] a, input logic [7:0] b,
                         input logic s, input string tag);
        int n;
        int cyc;
        int busy_cnt;
        logic [7:0] es;
        logic [7:0] prev;
        logic ec;
        logic eo;
        n = 8 >> k;
        model(a, b, s, es, ec, eo);
        @(negedge clk);
        check({tag, " ready"}, 32'(o_ready[k]), 32'd1);
        prev        = o_sum[k];
        st_start[k] = 1'b1;
        st_a[k]     = a;
        st_b[k]     = b;
        st_sub[k]   = s;
        @(negedge clk);
        st_start[k] = 1'b0;
        st_a[k]     = 8'($urandom);
        st_b[k]     = 8'($urandom);
        st_sub[k]   = 1'($urandom);
        cyc         = 0;
        busy_cnt    = 0;
        while (!o_done[k] && cyc <= n + 3) begin
            if (o_busy[k]) busy_cnt++;
            if (cyc == 1) check({tag, " sum held"}, 32'(o_sum[k]), 32'(prev));
            @(negedge clk);
            cyc++;
        end
        check({tag, " latency"}, 32'(cyc), 32'(n));
        check({tag, " busy cycles"}, 32'(busy_cnt), 32'(n));
        check({tag, " done"}, 32'(o_done[k]), 32'd1);
        check_result(tag, k, es, ec, eo);
        @(negedge clk);
        check({tag, " done pulse"}, 32'(o_done[k]), 32'd0);
    endtask

    // start held high across two operations; second accepted in the DONE cycle.
    task automatic stream(input int k, input logic [7:0] a1, input logic [7:0] b1, input logic s1,
                          input logic [7:0] a2, input logic [7:0] b2, input logic s2);
        int n;
        int cyc;
        logic [7:0] es1;
        logic [7:0] es2;
        logic ec1;
        logic ec2;
        logic eo1;
        logic eo2;
        n = 8 >> k;
        model(a1, b1, s1, es1, ec1, eo1);
        model(a2, b2, s2, es2, ec2, eo2);
        @(negedge clk);
        st_start[k] = 1'b1;
        st_a[k]     = a1;
        st_b[k]     = b1;
        st_sub[k]   = s1;
        @(negedge clk);
        st_a[k]   = a2;
        st_b[k]   = b2;
        st_sub[k] = s2;
        cyc       = 0;
        while (!o_done[k] && cyc <= n + 3) begin
            @(negedge clk);
            cyc++;
        end
        check("stream first latency", 32'(cyc), 32'(n));
        check_result("stream first", k, es1, ec1, eo1);
        @(negedge clk);
        st_start[k] = 1'b0;
        check("stream restart busy", 32'(o_busy[k]), 32'd1);
        cyc = 1;
        while (!o_done[k] && cyc <= n + 4) begin
            @(negedge clk);
            cyc++;
            st_start[k] = (cyc == 2 && n >= 4);
            if (cyc == 2) begin
                st_a[k] = 8'h55;
                st_b[k] = 8'h66;
            end
        end
        st_start[k] = 1'b0;
        check("stream done spacing", 32'(cyc), 32'(n + 1));
        check_result("stream second", k, es2, ec2, eo2);
        @(negedge clk);
        check("stream idle after", 32'(o_busy[k]), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        st_start = '0;
        st_sub   = '0;
        st_a     = '0;
        st_b     = '0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check("reset ready", 32'(o_ready[k]), 32'd1);
            check("reset busy",  32'(o_busy[k]),  32'd0);
            check("reset done",  32'(o_done[k]),  32'd0);
            check("reset sum",   32'(o_sum[k]),   32'd0);
            check("reset cout",  32'(o_cout[k]),  32'd0);
            check("reset ovf",   32'(o_ovf[k]),   32'd0);
        end
        rst_n = 1'b1;

        do_op(0, 8'h35, 8'h4A, 1'b0, "d1 35+4A");
        do_op(2, 8'h10, 8'h20, 1'b1, "d4 10-20");
        do_op(0, 8'h7F, 8'h01, 1'b0, "d1 7F+01");
        do_op(1, 8'h80, 8'h01, 1'b1, "d2 80-01");

        stream(0, 8'h12, 8'h34, 1'b0, 8'hFF, 8'h01, 1'b0);
        stream(2, 8'hC0, 8'h41, 1'b1, 8'hFF, 8'h01, 1'b0);

        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 15; i++) begin
                do_op(k, 8'($urandom), 8'($urandom), 1'($urandom), "random");
            end
        end

        // Reset at E3 of an 8-cycle op, with a nonzero result already held.
        do_op(0, 8'h21, 8'h11, 1'b0, "pre-reset");
        @(negedge clk);
        st_start[0] = 1'b1;
        st_a[0]     = 8'h40;
        st_b[0]     = 8'h02;
        st_sub[0]   = 1'b0;
        @(negedge clk);
        st_start[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midreset ready", 32'(o_ready[0]), 32'd1);
        check("midreset busy",  32'(o_busy[0]),  32'd0);
        check("midreset done",  32'(o_done[0]),  32'd0);
        check("midreset sum",   32'(o_sum[0]),   32'd0);
        check("midreset cout",  32'(o_cout[0]),  32'd0);
        check("midreset ovf",   32'(o_ovf[0]),   32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        do_op(0, 8'h01, 8'h01, 1'b0, "post-reset 01+01");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/add_sub_serial.md
# add_sub_serial

Parametrised, multi-cycle two's-complement adder/subtractor built from a chain of DIGIT full-adder cells with a registered carry. It processes a WIDTH-bit operand pair DIGIT bits per clock, LSB first, and reports sum, carry-out and signed overflow. It sits beside the combinational adder cells in the arithmetic library for area-constrained datapaths that can tolerate multi-cycle latency. A start/ready/done handshake sequences each operation.

## Interface
- WIDTH, 8, operand and result width in bits; must be ≥ 2.
- DIGIT, 1, bits processed per cycle; must divide WIDTH. N = WIDTH/DIGIT is the cycle count.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only when ready=1.
- sub  input  1  0 = a+b, 1 = a−b; sampled with start.
- a  input  WIDTH  operand A; sampled with start.
- b  input  WIDTH  operand B; sampled with start.
- ready  output  1  block can accept start this cycle.
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse; result valid.
- sum  output  WIDTH  result, held until the next result.
- cout  output  1  carry out of the MSB; for subtract, 1 = no borrow.
- ovf  output  1  signed overflow of the unsaturated result.

## Operation
- States: IDLE, RUN, DONE.
- IDLE: ready=1, busy=0. start=1 → latch a, b XOR {WIDTH{sub}} and carry=sub; clear digit counter; go to RUN.
- RUN: ready=0, busy=1. Each cycle adds the lowest DIGIT bits of the operand shift registers plus the registered carry, ripples through DIGIT full-adder cells, shifts the result digit into an internal result register and stores the new carry. The counter increments. On the Nth digit go to DONE.
- On the RUN→DONE edge:
  - sum ← internal result.
  - cout ← final carry.
  - ovf ← carry into MSB XOR carry out of MSB.
- DONE: done=1, ready=1, busy=0. start=1 → accept a new operation exactly as in IDLE and go to RUN. Otherwise go to IDLE.
- start in RUN is ignored. Operands may change freely after acceptance.
- sum, cout and ovf change only on the RUN→DONE edge.
- Reset, asserted at any time including mid-operation, aborts the operation. State → IDLE; all internal registers cleared.

## Timing
- Reset values: ready=1, busy=0, done=0, sum=0, cout=0, ovf=0. State is IDLE.
- start accepted at edge E0 → busy=1 from E0. Digits are processed at edges E1..EN. done=1 and results are valid from EN until EN+1.
- Latency from start acceptance to done is N cycles. Throughput is one result per N+1 cycles with start held high, because a DONE-cycle restart overlaps the done pulse.
- No combinational path from any input to any output. All outputs are registered.

## Configuration
- ADD_SUB_SAT_EN defined: on signed overflow, sum is clamped on the RUN→DONE edge. The clamp is 2^(WIDTH−1)−1 if the true result is positive and −2^(WIDTH−1) if negative; the sign is taken from operand A's MSB. ovf and cout still report the unsaturated result.
- ADD_SUB_SAT_EN undefined: sum wraps modulo 2^WIDTH. No clamp logic is synthesised.

## Test plan
- WIDTH=8, DIGIT=1: start with a=0x35, b=0x4A, sub=0. At E8 expect done=1, sum=0x7F, cout=0, ovf=0. busy is high for exactly 8 cycles.
- WIDTH=8, DIGIT=4: start with a=0x10, b=0x20, sub=1. At E2 expect sum=0xF0, cout=0, ovf=0.
- WIDTH=8, DIGIT=1: a=0x7F, b=0x01, sub=0. Expect ovf=1 and cout=0. sum=0x80 without ADD_SUB_SAT_EN; sum=0x7F with it.
- WIDTH=8, DIGIT=2: a=0x80, b=0x01, sub=1. Expect ovf=1 and cout=1. sum=0x7F without ADD_SUB_SAT_EN; sum=0x80 with it.
- Hold start high with two operand pairs:
  - Second op (0xFF+0x01) is accepted in the DONE cycle; done pulses are N+1 cycles apart.
  - Second result: sum=0x00, cout=1, ovf=0.
  - A start pulse mid-RUN has no effect.
- Assert rst_n=0 at E3 of an 8-cycle op (DIGIT=1), release after 2 cycles. Expect immediately ready=1, busy=0, done=0, sum=0, cout=0, ovf=0. A new op 0x01+0x01 then yields sum=0x02.
